// File: rtl/wdb_pkg.sv
// Shared definitions for the write-data buffer controller and its SRAM wrapper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wdb_pkg;

    // Default geometry: one DFI write burst entry per slot, 64 slots.
    localparam int WDB_DATA_W = 518;
    localparam int WDB_DEPTH  = 64;
    localparam int WDB_AW     = 6;

    // Slot tag as seen by the host and by the DFI write path.
    typedef logic [WDB_AW-1:0] wdb_tag_t;

    // Which client owns the single SRAM port this cycle.
    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_WRITE = 2'd1,
        ACC_READ  = 2'd2
    } wdb_acc_e;

endpackage

// File: rtl/wdb_prio_enc.sv
// Lowest-index set-bit finder used to pick the next free buffer slot.
// Latency: purely combinational.
// Backpressure: none; found_o low means no bit is set.
module wdb_prio_enc #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic [DEPTH-1:0] vec_i,
    output logic [AW-1:0]    idx_o,
    output logic             found_o
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = AW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wr_data_buf_ctrl.sv
// Write-data buffer controller: slot allocation, single-port SRAM arbitration, tagged read-out.
// Latency: write accepted in 0 cycles (tag combinational); read data 1 cycle after request.
// Backpressure: wd_ready drops when full or when a read owns the SRAM port; reads never stall.
// Optional feature macro: WDB_DOUBLE_FREE_CHK_EN adds the sticky err_double_free output.
module wr_data_buf_ctrl
    import wdb_pkg::*;
#(
    parameter int DATA_W = WDB_DATA_W,
    parameter int DEPTH  = WDB_DEPTH,
    parameter int AW     = WDB_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    // host write side
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic [AW-1:0]     wd_tag,
    // DFI write path read side
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [AW-1:0]     rd_req_tag,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW-1:0]     rd_data_tag,
    // single-port SRAM, combinational read
    output logic              sram_cs_n,
    output logic              sram_wr_n,
    output logic [AW-1:0]     sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    // occupancy
    output logic [AW:0]       free_cnt
`ifdef WDB_DOUBLE_FREE_CHK_EN
    ,
    output logic              err_double_free
`endif
);

    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    // bitmap bit set = slot holds data not yet read out
    logic [DEPTH-1:0]  bitmap_q, bitmap_d;
    logic [AW:0]       free_cnt_q, free_cnt_d;
    logic              rd_data_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [AW-1:0]     rd_data_tag_q;

    logic [AW-1:0]     free_idx;
    logic              free_found;
    logic              slot_busy;
    logic              not_full;
    wdb_acc_e          acc;

    wdb_prio_enc #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prio_enc (
        .vec_i   (~bitmap_q),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    assign not_full  = (free_cnt_q != '0) && free_found;
    assign slot_busy = bitmap_q[rd_req_tag];

    // Arbitrate the SRAM port: reads first, writes only when a slot is free; nothing while in reset.
    always_comb begin
        acc = ACC_IDLE;
        if (rst_n) begin
            if (rd_req_valid) begin
                acc = ACC_READ;
            end else if (wd_valid && not_full) begin
                acc = ACC_WRITE;
            end
        end
    end

    assign wd_ready     = rst_n && not_full && !rd_req_valid;
    assign wd_tag       = free_idx;
    assign rd_req_ready = 1'b1;

    // SRAM strobes follow the arbitration result in the same cycle.
    always_comb begin
        sram_cs_n = (acc == ACC_IDLE);
        sram_wr_n = (acc != ACC_WRITE);
        sram_addr = (acc == ACC_READ) ? rd_req_tag : free_idx;
        sram_din  = wd_data;
    end

    // Allocation bookkeeping: a write claims the lowest free slot, a read releases an allocated one.
    // A read of an already-free slot changes nothing, so the count can never overshoot DEPTH.
    always_comb begin
        bitmap_d   = bitmap_q;
        free_cnt_d = free_cnt_q;
        case (acc)
            ACC_WRITE: begin
                bitmap_d[free_idx] = 1'b1;
                free_cnt_d         = free_cnt_q - CNT_ONE;
            end
            ACC_READ: begin
                if (slot_busy) begin
                    bitmap_d[rd_req_tag] = 1'b0;
                    free_cnt_d           = free_cnt_q + CNT_ONE;
                end
            end
            default: begin
            end
        endcase
    end

    // Allocation state; SRAM contents are left alone since every slot is free after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitmap_q   <= '0;
            free_cnt_q <= CNT_FULL;
        end else begin
            bitmap_q   <= bitmap_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    // Read-data register: captures the combinational SRAM output at the end of the read cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
            rd_data_tag_q   <= '0;
        end else begin
            rd_data_valid_q <= (acc == ACC_READ);
            if (acc == ACC_READ) begin
                rd_data_q     <= sram_dout;
                rd_data_tag_q <= rd_req_tag;
            end
        end
    end

    assign rd_data_valid = rd_data_valid_q;
    assign rd_data       = rd_data_q;
    assign rd_data_tag   = rd_data_tag_q;
    assign free_cnt      = free_cnt_q;

`ifdef WDB_DOUBLE_FREE_CHK_EN
    logic err_double_free_q;

    // Sticky flag for a read of a slot that holds nothing; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_double_free_q <= 1'b0;
        end else if ((acc == ACC_READ) && !slot_busy) begin
            err_double_free_q <= 1'b1;
        end
    end

    assign err_double_free = err_double_free_q;
`endif

endmodule

// File: tb/tb_wr_data_buf_ctrl.sv
// Self-checking bench for wr_data_buf_ctrl: directed table, corner sequences, random traffic.
// Build with WDB_DOUBLE_FREE_CHK_EN defined to exercise the double-free flag.
module tb_wr_data_buf_ctrl;

    localparam int DATA_W = 518;
    localparam int DEPTH  = 64;
    localparam int AW     = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;
    logic [AW-1:0]     wd_tag;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [AW-1:0]     rd_req_tag;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic [AW-1:0]     rd_data_tag;
    logic              sram_cs_n;
    logic              sram_wr_n;
    logic [AW-1:0]     sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;
    logic [AW:0]       free_cnt;
`ifdef WDB_DOUBLE_FREE_CHK_EN
    logic              err_double_free;
`endif

    always #5 clk = ~clk;

    wr_data_buf_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wd_valid      (wd_valid),
        .wd_ready      (wd_ready),
        .wd_data       (wd_data),
        .wd_tag        (wd_tag),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_tag    (rd_req_tag),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .rd_data_tag   (rd_data_tag),
        .sram_cs_n     (sram_cs_n),
        .sram_wr_n     (sram_wr_n),
        .sram_addr     (sram_addr),
        .sram_din      (sram_din),
        .sram_dout     (sram_dout),
        .free_cnt      (free_cnt)
`ifdef WDB_DOUBLE_FREE_CHK_EN
        ,
        .err_double_free (err_double_free)
`endif
    );

    // Single-port SRAM with combinational read, never cleared.
    logic [DATA_W-1:0] mem [DEPTH];
    assign sram_dout = mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_cs_n && !sram_wr_n) mem[sram_addr] <= sram_din;
    end

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [543:0] t;
        for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
        return t[DATA_W-1:0];
    endfunction

    // ---------------- reference model: occupancy set plus stored data ----------------
    bit                occ  [DEPTH];
    logic [DATA_W-1:0] mdat [DEPTH];
    int                m_free;
    bit                m_init = 0;
    bit                m_rvld;
    bit                m_tag_known, m_dat_known;
    int                m_rtag;
    logic [DATA_W-1:0] m_rdat;
    bit                m_err;

    function automatic int lowest_free();
        for (int i = 0; i < DEPTH; i++) if (!occ[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) occ[i] = 0;
        m_free = DEPTH; m_rvld = 0; m_tag_known = 1; m_dat_known = 1;
        m_rtag = 0; m_rdat = '0; m_err = 0; m_init = 1;
    endtask

    // One clock cycle: check registered outputs, drive, check combinational outputs, advance model.
    task automatic step(input bit rst, input bit rv, input int rtag, input bit wv, input logic [DATA_W-1:0] wdat);
        int  e_tag;
        bit  e_rdy, e_wacc, e_racc;
        @(negedge clk);
        if (m_init) begin
            check("rd_data_valid", rd_data_valid, m_rvld);
            if (m_tag_known) check("rd_data_tag", rd_data_tag, m_rtag);
            if (m_dat_known) check("rd_data", rd_data, m_rdat);
            check("free_cnt", free_cnt, m_free);
`ifdef WDB_DOUBLE_FREE_CHK_EN
            check("err_double_free", err_double_free, m_err);
`endif
        end
        rst_n = rst; rd_req_valid = rv; rd_req_tag = AW'(rtag); wd_valid = wv; wd_data = wdat;
        #1;
        if (!m_init) return;
        e_tag  = lowest_free();
        e_rdy  = rst && (m_free > 0) && !rv;
        e_wacc = wv && e_rdy;
        e_racc = rst && rv;
        check("wd_ready", wd_ready, e_rdy);
        check("rd_req_ready", rd_req_ready, 1'b1);
        if (m_free > 0) check("wd_tag", wd_tag, e_tag);
        check("sram_cs_n", sram_cs_n, !(e_wacc || e_racc));
        if (e_wacc || e_racc) begin
            check("sram_wr_n", sram_wr_n, !e_wacc);
            check("sram_addr", sram_addr, e_racc ? rtag : e_tag);
        end
        if (e_wacc) check("sram_din", sram_din, wdat);
        if (!rst) begin
            model_reset();
        end else if (rv) begin
            m_rvld = 1; m_tag_known = 1; m_rtag = rtag;
            if (occ[rtag]) begin
                m_dat_known = 1; m_rdat = mdat[rtag];
                occ[rtag] = 0; m_free++;
            end else begin
                m_dat_known = 0; m_err = 1;
            end
        end else begin
            m_rvld = 0; m_tag_known = 0; m_dat_known = 0;
            if (e_wacc) begin
                occ[e_tag] = 1; mdat[e_tag] = wdat; m_free--;
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit rst; bit rv; int rtag; bit wv; int wsel;
        bit e_wrdy; int e_tag; int e_free; bit e_rvld; int e_rtag; int e_rsel;
    } vec_t;

    vec_t              tbl [10];
    logic [DATA_W-1:0] pat [4];

    initial begin
        rst_n = 0; wd_valid = 0; wd_data = '0; rd_req_valid = 0; rd_req_tag = '0;
        for (int i = 0; i < 4; i++) pat[i] = rnd_data();
        //         rst rv rt wv ws  wrdy tag free rvld rtag rsel
        tbl[0] = '{0, 0, 0, 1, 0,  0,   0,  64,  0,   0,  -1};
        tbl[1] = '{1, 0, 0, 1, 0,  1,   0,  63,  0,   0,  -1};  // A -> 0
        tbl[2] = '{1, 0, 0, 1, 1,  1,   1,  62,  0,   0,  -1};  // B -> 1
        tbl[3] = '{1, 0, 0, 1, 2,  1,   2,  61,  0,   0,  -1};  // C -> 2
        tbl[4] = '{1, 1, 1, 1, 3,  0,   3,  62,  1,   1,   1};  // read B, D stalled
        tbl[5] = '{1, 0, 0, 1, 3,  1,   1,  61,  0,   0,  -1};  // D reuses slot 1
        tbl[6] = '{1, 1, 1, 0, 0,  0,   3,  62,  1,   1,   3};  // read D next cycle
        tbl[7] = '{1, 0, 0, 0, 0,  1,   1,  62,  0,   0,  -1};
        tbl[8] = '{1, 1, 0, 0, 0,  0,   1,  63,  1,   0,   0};  // read A
        tbl[9] = '{1, 0, 0, 0, 0,  1,   0,  63,  0,   0,  -1};

        repeat (2) @(posedge clk);
        model_reset();

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rst, tbl[i].rv, tbl[i].rtag, tbl[i].wv, pat[tbl[i].wsel]);
            check($sformatf("tbl%0d wd_ready", i), wd_ready, tbl[i].e_wrdy);
            check($sformatf("tbl%0d wd_tag", i), wd_tag, tbl[i].e_tag);
            if (tbl[i].wv && tbl[i].e_wrdy) begin
                check($sformatf("tbl%0d wr strobe", i), {sram_cs_n, sram_wr_n}, 2'b00);
                check($sformatf("tbl%0d wr addr", i), sram_addr, tbl[i].e_tag);
            end
            @(posedge clk); #1;
            check($sformatf("tbl%0d free_cnt", i), free_cnt, tbl[i].e_free);
            check($sformatf("tbl%0d rd_data_valid", i), rd_data_valid, tbl[i].e_rvld);
            if (tbl[i].e_rvld) begin
                check($sformatf("tbl%0d rd_data_tag", i), rd_data_tag, tbl[i].e_rtag);
                check($sformatf("tbl%0d rd_data", i), rd_data, pat[tbl[i].e_rsel]);
            end
        end

        // ---- fill all 64 slots, then free slot 40 ----
        step(0, 0, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 1, rnd_data());
        step(1, 0, 0, 1, rnd_data());
        check("full free_cnt", free_cnt, 0);
        check("full wd_ready", wd_ready, 1'b0);
        step(1, 1, 40, 1, pat[0]);
        check("full read wd_ready", wd_ready, 1'b0);
        step(1, 0, 0, 1, pat[0]);
        check("after free wd_ready", wd_ready, 1'b1);
        check("after free wd_tag", wd_tag, 40);
        step(1, 0, 0, 0, '0);
        check("refill free_cnt", free_cnt, 0);

        // ---- reset in the middle of a write burst ----
        step(0, 0, 0, 0, '0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1, rnd_data());
        step(0, 0, 0, 1, rnd_data());
        step(1, 0, 0, 0, '0);
        check("mid reset free_cnt", free_cnt, 64);
        check("mid reset rd_data_valid", rd_data_valid, 1'b0);
        check("mid reset wd_tag", wd_tag, 0);

`ifdef WDB_DOUBLE_FREE_CHK_EN
        // ---- read of a never-written slot ----
        step(0, 0, 0, 0, '0);
        step(1, 1, 5, 0, '0);
        step(1, 0, 0, 0, '0);
        check("dfree err set", err_double_free, 1'b1);
        check("dfree free_cnt", free_cnt, 64);
        repeat (3) step(1, 0, 0, 0, '0);
        check("dfree err sticky", err_double_free, 1'b1);
`endif

        // ---- random traffic against the model ----
        for (int c = 0; c < 3000; c++) begin
            bit rst, rv, wv, hit;
            int t, s;
            rst = ($urandom_range(199) != 0);
            rv  = ($urandom_range(9) < 3);
            wv  = ($urandom_range(9) < 6);
            t   = $urandom_range(DEPTH - 1);
            if (rv && m_free < DEPTH && $urandom_range(4) != 0) begin
                s = $urandom_range(DEPTH - 1);
                hit = 0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (!hit && occ[(s + k) % DEPTH]) begin
                        t = (s + k) % DEPTH;
                        hit = 1;
                    end
                end
            end
            step(rst, rv, t, wv, rnd_data());
        end
        step(1, 0, 0, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
